// File: rtl/timer_bus_if.sv
// Peripheral bus request signals shared by the timer controller and its bus master.
// Tri-state return signals (data_o, ack_o) stay as plain inout ports on the peripheral.
interface timer_bus_if;
    logic        write_i;
    logic        read_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;

    modport master (
        output write_i,
        output read_i,
        output addr_i,
        output data_i
    );

    modport slave (
        input write_i,
        input read_i,
        input addr_i,
        input data_i
    );
endinterface

// File: rtl/timer_ctrl.sv
// Memory-mapped interval timer: prescaled up-counter compared against COMPARE,
// periodic or one-shot, with sticky W1C match status and a level interrupt.
module timer_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned PRE_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    timer_bus_if.slave  bus,
    inout  wire  [31:0] data_o,
    inout  wire         ack_o,
    output logic        irq_o
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COMPARE  = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               ctrl_oneshot;
    logic               ctrl_ie;
    logic [PRE_W-1:0]   prescale;
    logic [PRE_W-1:0]   pcnt;
    logic [CNT_W-1:0]   compare;
    logic [CNT_W-1:0]   count;
    logic               match;

    logic [2:0]  widx;
    logic        in_win;
    logic        in_map;
    logic        sel;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_compare;
    logic        wr_count;
    logic        wr_status;
    logic [31:0] rdata;

    logic tick;
    logic hit;
    logic en_off;
    logic match_nxt;
    logic ie_nxt;

    // Address decode: 32-byte window, word-aligned offsets 0x00..0x10 only
    assign widx        = bus.addr_i[4:2];
    assign in_win      = (bus.addr_i[31:5] == BASE_ADDR[31:5]);
    assign in_map      = (bus.addr_i[1:0] == 2'b00) && (widx <= OFF_STATUS);
    assign sel         = in_win && in_map && (bus.read_i || bus.write_i);
    assign wr          = sel && bus.write_i;
    assign wr_ctrl     = wr && (widx == OFF_CTRL);
    assign wr_prescale = wr && (widx == OFF_PRESCALE);
    assign wr_compare  = wr && (widx == OFF_COMPARE);
    assign wr_count    = wr && (widx == OFF_COUNT);
    assign wr_status   = wr && (widx == OFF_STATUS);

    always_comb begin
        rdata = 32'h0;
        case (widx)
            OFF_CTRL:     rdata = {29'h0, ctrl_ie, ctrl_oneshot, (state == RUN)};
            OFF_PRESCALE: rdata = 32'(prescale);
            OFF_COMPARE:  rdata = 32'(compare);
            OFF_COUNT:    rdata = 32'(count);
            OFF_STATUS:   rdata = {31'h0, match};
            default:      rdata = 32'h0;
        endcase
    end

    assign data_o = sel ? rdata : 32'bz;
    assign ack_o  = sel ? 1'b1  : 1'bz;

    // A same-cycle EN=0 write aborts the tick; a W1C loses to a hardware set
    always_comb begin
        tick      = (state == RUN) && (pcnt == prescale);
        hit       = tick && (count == compare);
        en_off    = wr_ctrl && !bus.data_i[0];
        match_nxt = match;
        if (wr_status && bus.data_i[0]) begin
            match_nxt = 1'b0;
        end
        if (hit && !en_off) begin
            match_nxt = 1'b1;
        end
        ie_nxt = wr_ctrl ? bus.data_i[2] : ctrl_ie;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ctrl_oneshot <= 1'b0;
            ctrl_ie      <= 1'b0;
            prescale     <= '0;
            pcnt         <= '0;
            compare      <= '0;
            count        <= '0;
            match        <= 1'b0;
            irq_o        <= 1'b0;
        end else begin
            match   <= match_nxt;
            ctrl_ie <= ie_nxt;
            irq_o   <= match_nxt && ie_nxt;

            if (state == RUN) begin
                if (tick) begin
                    pcnt <= '0;
                    if (hit) begin
                        if (ctrl_oneshot) begin
                            state <= DONE;
                        end else begin
                            count <= '0;
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end else begin
                    pcnt <= pcnt + PRE_W'(1);
                end
            end

            // Bus writes override the hardware update of the same cycle
            if (wr_prescale) prescale <= PRE_W'(bus.data_i);
            if (wr_compare)  compare  <= CNT_W'(bus.data_i);
            if (wr_count)    count    <= CNT_W'(bus.data_i);

            if (wr_ctrl) begin
                ctrl_oneshot <= bus.data_i[1];
                if (bus.data_i[0]) begin
                    if (state != RUN) begin
                        state <= RUN;
                        count <= '0;
                        pcnt  <= '0;
                    end
                end else begin
                    state <= IDLE;
                    count <= count;
                    pcnt  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized and directed bench for timer_ctrl; a reference model predicts every
// bus response and irq level, and a negedge monitor checks them from a queue.
module tb_timer_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0010;
    localparam logic [31:0] WIN  = {BASE[31:5], 5'b0};

    logic        clk = 1'b0;
    logic        rst;
    wire  [31:0] data_o;
    wire         ack_o;
    logic        irq_o;

    timer_bus_if bus ();

    timer_ctrl #(.BASE_ADDR(BASE), .CNT_W(32), .PRE_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .data_o (data_o),
        .ack_o  (ack_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ack;
        bit          rd;
        logic [31:0] data;
        bit          irq;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: running flag plus plain register values
    bit          m_run;
    bit          m_os;
    bit          m_ie;
    logic [15:0] m_pre;
    logic [15:0] m_pcnt;
    logic [31:0] m_cmp;
    logic [31:0] m_cnt;
    bit          m_match;

    function automatic void m_reset();
        m_run = 0; m_os = 0; m_ie = 0; m_pre = 0; m_pcnt = 0;
        m_cmp = 0; m_cnt = 0; m_match = 0;
    endfunction

    function automatic bit m_sel(input logic [31:0] a, input bit w, input bit rd);
        int unsigned off;
        off = a % 32;
        return ((a >> 5) == (BASE >> 5)) && (off % 4 == 0) && (off <= 16) && (w || rd);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a % 32)
            0:       return {29'h0, m_ie, m_os, m_run};
            4:       return {16'h0, m_pre};
            8:       return m_cmp;
            12:      return m_cnt;
            16:      return {31'h0, m_match};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_hit_now();
        return m_run && (m_pcnt == m_pre) && (m_cnt == m_cmp);
    endfunction

    function automatic void m_step(input bit r, input bit w, input bit rd,
                                   input logic [31:0] a, input logic [31:0] d);
        bit          s, tick, hit, stop, was_run, set;
        int unsigned off;
        if (r) begin
            m_reset();
            return;
        end
        s       = m_sel(a, w, rd) && w;
        off     = a % 32;
        was_run = m_run;
        tick    = m_run && (m_pcnt == m_pre);
        hit     = tick && (m_cnt == m_cmp);
        stop    = s && (off == 0) && !d[0];
        set     = hit && !stop;
        if (m_run && !stop) begin
            if (tick) begin
                m_pcnt = 0;
                if (hit) begin
                    if (m_os) m_run = 0;
                    else      m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_pcnt = m_pcnt + 1;
            end
        end
        if (s && off == 16 && d[0]) m_match = 0;
        if (set) m_match = 1;
        if (s && off == 4)  m_pre = d[15:0];
        if (s && off == 8)  m_cmp = d;
        if (s && off == 12) m_cnt = d;
        if (s && off == 0) begin
            m_os = d[1];
            m_ie = d[2];
            if (d[0]) begin
                if (!was_run) begin
                    m_run = 1; m_cnt = 0; m_pcnt = 0;
                end
            end else begin
                m_run = 0; m_pcnt = 0;
            end
        end
    endfunction

    // One bus cycle: drive, queue the predicted response, advance the model
    task automatic cyc(input bit r, input bit w, input bit rd,
                       input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        rst         = r;
        bus.write_i = w;
        bus.read_i  = rd;
        bus.addr_i  = a;
        bus.data_i  = d;
        e.ack  = m_sel(a, w, rd);
        e.rd   = e.ack && rd;
        e.data = m_read(a);
        e.irq  = m_match && m_ie;
        exp_q.push_back(e);
        m_step(r, w, rd, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        cyc(0, 1, 0, WIN + off, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(0, 0, 1, a, 32'h0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 5; i++) rd(WIN + 32'(4 * i));
    endtask

    task automatic wait_hit(input string name);
        int n;
        n = 0;
        while (!m_hit_now() && n < 200) begin
            rd(WIN + 32'hC);
            n++;
        end
        if (!m_hit_now()) begin
            checks++;
            failures++;
            $display("FAIL %s: no match tick within %0d cycles", name, n);
        end
    endtask

    // Monitor: compare DUT outputs against the queued predictions
    initial begin
        exp_t e;
        bit   ack_seen;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                ack_seen = (ack_o === 1'b1);
                checks++;
                if (ack_seen != e.ack) begin
                    failures++;
                    $display("FAIL ack: got %b expected %b addr=%h", ack_seen, e.ack, bus.addr_i);
                end
                if (e.rd) begin
                    checks++;
                    if (data_o !== e.data) begin
                        failures++;
                        $display("FAIL rdata: got %h expected %h addr=%h", data_o, e.data, bus.addr_i);
                    end
                end
                checks++;
                if (irq_o !== e.irq) begin
                    failures++;
                    $display("FAIL irq: got %b expected %b", irq_o, e.irq);
                end
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        int          k, r;
        bit          w, rdb;

        rst = 1'b1;
        bus.write_i = 1'b0;
        bus.read_i  = 1'b0;
        bus.addr_i  = 32'h0;
        bus.data_i  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();

        read_all();

        // Periodic, PRESCALE=0, COMPARE=3, IE set
        wr(32'h4, 32'h0);
        wr(32'h8, 32'h3);
        wr(32'h0, 32'h5);
        repeat (10) rd(WIN + 32'hC);
        read_all();

        // One-shot, PRESCALE=2, COMPARE=1, IE clear
        wr(32'h0, 32'h0);
        wr(32'h10, 32'h1);
        wr(32'h4, 32'h2);
        wr(32'h8, 32'h1);
        wr(32'h0, 32'h3);
        repeat (12) rd(WIN + 32'hC);
        read_all();

        // W1C colliding with a match tick, then a clean W1C
        wr(32'h10, 32'h1);
        wr(32'h4, 32'h1);
        wr(32'h8, 32'h2);
        wr(32'h0, 32'h5);
        wait_hit("collide");
        wr(32'h10, 32'h1);
        rd(WIN + 32'h10);
        wr(32'h10, 32'h1);
        rd(WIN + 32'h10);
        rd(WIN + 32'h10);

        // COUNT overwrite near wrap
        wr(32'h0, 32'h0);
        wr(32'h10, 32'h1);
        wr(32'h4, 32'h0);
        wr(32'h8, 32'h5);
        wr(32'h0, 32'h1);
        rd(WIN + 32'hC);
        wr(32'hC, 32'hFFFF_FFFF);
        repeat (9) rd(WIN + 32'hC);
        read_all();

        // Unmapped and misaligned accesses must be ignored
        rd(WIN + 32'h14);
        rd(WIN + 32'h18);
        rd(BASE + 32'h1);
        rd(BASE + 32'h14);
        cyc(0, 1, 1, WIN + 32'h14, 32'hFFFF_FFFF);
        cyc(0, 1, 0, WIN + 32'h1, 32'h0);
        cyc(0, 1, 0, WIN + 32'h20, 32'h0);
        read_all();

        // Reset mid-run with MATCH set and a colliding CTRL write
        wr(32'h4, 32'h0);
        wr(32'h8, 32'h1);
        wr(32'h0, 32'h5);
        repeat (4) rd(WIN + 32'h10);
        cyc(1, 1, 0, WIN, 32'h5);
        read_all();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r   = int'($urandom_range(99));
            k   = int'($urandom_range(9));
            d   = $urandom;
            case (k)
                0, 1: begin a = WIN;        d = {29'h0, d[2], d[1], (d[4:3] != 2'b00)}; end
                2:    begin a = WIN + 4;    d = 32'($urandom_range(3)); end
                3:    begin a = WIN + 8;    d = 32'($urandom_range(6)); end
                4:    begin a = WIN + 12;   d = ($urandom_range(9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(8)); end
                5, 6: begin a = WIN + 16; end
                7:    a = WIN + 32'(4 * $urandom_range(5, 7));
                8:    a = WIN + 32'($urandom_range(1, 3)) + 32'(4 * $urandom_range(4));
                default: a = WIN + 32'h20 + 32'(4 * $urandom_range(4));
            endcase
            if (r < 1) begin
                cyc(1, $urandom_range(1) == 1, 0, a, d);
            end else if (r < 40) begin
                cyc(0, 0, 0, a, d);
            end else if (r < 75) begin
                cyc(0, 0, 1, a, d);
            end else begin
                w   = 1'b1;
                rdb = ($urandom_range(3) == 0);
                cyc(0, w, rdb, a, d);
            end
        end
        read_all();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
